axi_lite_slave: RTL and testbench

AXI_LITE_SLAVE -- requirements
Module: axi_lite_slave

---
 rtl/axi_lite_slave.sv | 218 +++++++++++++++++++++
 tb/tb_axi_lite_slave.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_slave.sv
// AXI4-Lite register-bank slave: NREGS word registers with byte strobes.
// Ports: clk/rst, AXI-Lite AW/W/B/AR/R channels, regs_out flattened bank.
module axi_lite_slave #(
    parameter int AXI_ADDRW = 32,
    parameter int AXI_DATAW = 32,
    parameter int NREGS     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [AXI_ADDRW-1:0]       awaddr,
    input  logic [2:0]                 awprot,
    input  logic                       awvalid,
    output logic                       awready,
    input  logic [AXI_DATAW-1:0]       wdata,
    input  logic [AXI_DATAW/8-1:0]     wstrb,
    input  logic                       wvalid,
    output logic                       wready,
    output logic [1:0]                 bresp,
    output logic                       bvalid,
    input  logic                       bready,
    input  logic [AXI_ADDRW-1:0]       araddr,
    input  logic [2:0]                 arprot,
    input  logic                       arvalid,
    output logic                       arready,
    output logic [AXI_DATAW-1:0]       rdata,
    output logic [1:0]                 rresp,
    output logic                       rvalid,
    input  logic                       rready,
    output logic [NREGS*AXI_DATAW-1:0] regs_out
);

    localparam int NB   = AXI_DATAW / 8;
    localparam int IDXW = $clog2(NREGS);
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} w_state_t;
    typedef enum logic {R_IDLE, R_RESP} r_state_t;

    w_state_t w_state_q, w_state_d;
    r_state_t r_state_q, r_state_d;

    logic [AXI_DATAW-1:0] regs_q [NREGS];

    logic                 aw_got_q, aw_got_d;
    logic                 w_got_q, w_got_d;
    logic [AXI_ADDRW-1:0] awaddr_q, awaddr_d;
    logic [AXI_DATAW-1:0] wdata_q, wdata_d;
    logic [NB-1:0]        wstrb_q, wstrb_d;
    logic                 awready_q, awready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic [1:0]           bresp_q, bresp_d;
    logic                 arready_q, arready_d;
    logic                 rvalid_q, rvalid_d;
    logic [1:0]           rresp_q, rresp_d;
    logic [AXI_DATAW-1:0] rdata_q, rdata_d;

    logic                 aw_hs, w_hs, aw_have, w_have;
    logic                 cm_we;
    logic [AXI_ADDRW-1:0] cm_addr;
    logic [AXI_DATAW-1:0] cm_data;
    logic [NB-1:0]        cm_strb;
    logic                 cm_ok;
    logic                 rd_ok;
    logic [IDXW-1:0]      rd_idx;

    logic unused_ok;
    assign unused_ok = ^{awprot, arprot, awaddr_q[1:0], araddr[1:0]};

    assign aw_hs   = awready_q & awvalid;
    assign w_hs    = wready_q & wvalid;
    assign aw_have = aw_got_q | aw_hs;
    assign w_have  = w_got_q | w_hs;

    // The commit uses whichever copy (live input or captured) is current.
    assign cm_addr = aw_hs ? awaddr : awaddr_q;
    assign cm_data = w_hs ? wdata : wdata_q;
    assign cm_strb = w_hs ? wstrb : wstrb_q;
    assign cm_ok   = (cm_addr >> (IDXW + 2)) == '0;

    assign rd_ok  = (araddr >> (IDXW + 2)) == '0;
    assign rd_idx = araddr[IDXW+1:2];

    always_comb begin
        w_state_d = w_state_q;
        aw_got_d  = aw_got_q;
        w_got_d   = w_got_q;
        awaddr_d  = awaddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        awready_d = awready_q;
        wready_d  = wready_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        cm_we     = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs) awaddr_d = awaddr;
                if (w_hs) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                end
                if (aw_have && w_have) begin
                    cm_we     = cm_ok;
                    bresp_d   = cm_ok ? OKAY : SLVERR;
                    bvalid_d  = 1'b1;
                    awready_d = 1'b0;
                    wready_d  = 1'b0;
                    aw_got_d  = 1'b0;
                    w_got_d   = 1'b0;
                    w_state_d = W_RESP;
                end else begin
                    aw_got_d  = aw_have;
                    w_got_d   = w_have;
                    awready_d = !aw_have;
                    wready_d  = !w_have;
                end
            end
            W_RESP: begin
                if (bready) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Reads sample regs_q before this cycle's commit lands: old value wins.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rresp_d   = rresp_q;
        rdata_d   = rdata_q;
        case (r_state_q)
            R_IDLE: begin
                if (arready_q && arvalid) begin
                    rvalid_d  = 1'b1;
                    arready_d = 1'b0;
                    rdata_d   = rd_ok ? regs_q[rd_idx] : '0;
                    rresp_d   = rd_ok ? OKAY : SLVERR;
                    r_state_d = R_RESP;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_RESP: begin
                if (rready) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            w_state_q <= W_IDLE;
            r_state_q <= R_IDLE;
            aw_got_q  <= 1'b0;
            w_got_q   <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rresp_q   <= OKAY;
            rdata_q   <= '0;
            for (int k = 0; k < NREGS; k++) regs_q[k] <= '0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            aw_got_q  <= aw_got_d;
            w_got_q   <= w_got_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            if (cm_we) begin
                for (int b = 0; b < NB; b++) begin
                    if (cm_strb[b])
                        regs_q[cm_addr[IDXW+1:2]][b*8 +: 8] <= cm_data[b*8 +: 8];
                end
            end
        end
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rresp   = rresp_q;
    assign rdata   = rdata_q;

    for (genvar k = 0; k < NREGS; k++) begin : g_out
        assign regs_out[k*AXI_DATAW +: AXI_DATAW] = regs_q[k];
    end

endmodule

// File: tb/tb_axi_lite_slave.sv
// Self-checking bench for axi_lite_slave: cycle model plus directed vectors.
// Drives inputs on the falling edge, checks outputs 1ns after the rising edge.
module tb_axi_lite_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NR = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [AW-1:0]    awaddr = '0;
    logic [2:0]       awprot = '0;
    logic             awvalid = 1'b0;
    logic             awready;
    logic [DW-1:0]    wdata = '0;
    logic [DW/8-1:0]  wstrb = '0;
    logic             wvalid = 1'b0;
    logic             wready;
    logic [1:0]       bresp;
    logic             bvalid;
    logic             bready = 1'b1;
    logic [AW-1:0]    araddr = '0;
    logic [2:0]       arprot = '0;
    logic             arvalid = 1'b0;
    logic             arready;
    logic [DW-1:0]    rdata;
    logic [1:0]       rresp;
    logic             rvalid;
    logic             rready = 1'b1;
    logic [NR*DW-1:0] regs_out;

    axi_lite_slave #(.AXI_ADDRW(AW), .AXI_DATAW(DW), .NREGS(NR)) dut (
        .clk(clk), .rst(rst),
        .awaddr(awaddr), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
        .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .araddr(araddr), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .regs_out(regs_out)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction-level model of what the slave must show after each edge.
    logic          m_rst;
    logic          m_awr, m_wr, m_arr, m_bv, m_rv;
    logic [1:0]    m_br, m_rr;
    logic [31:0]   m_rd;
    logic          m_gaw, m_gw;
    logic [31:0]   m_a, m_d;
    logic [3:0]    m_s;
    logic [31:0]   mregs [NR];

    always @(posedge clk) begin
        if (rst) begin
            m_rst = 1'b1;
            m_awr = 0; m_wr = 0; m_arr = 0; m_bv = 0; m_rv = 0;
            m_br = 0; m_rr = 0; m_rd = 0; m_gaw = 0; m_gw = 0;
            for (int k = 0; k < NR; k++) mregs[k] = 0;
        end else begin
            m_rst = 1'b0;
            if (m_rv) begin
                if (rready) begin m_rv = 0; m_arr = 1; end
            end else if (m_arr && arvalid) begin
                m_rv = 1; m_arr = 0;
                if (araddr < NR * 4) begin
                    m_rd = mregs[araddr / 4]; m_rr = 2'b00;
                end else begin
                    m_rd = 0; m_rr = 2'b10;
                end
            end else begin
                m_arr = 1;
            end
            if (m_bv) begin
                if (bready) begin m_bv = 0; m_awr = 1; m_wr = 1; end
            end else begin
                if (m_awr && awvalid) begin m_gaw = 1; m_a = awaddr; end
                if (m_wr && wvalid) begin m_gw = 1; m_d = wdata; m_s = wstrb; end
                if (m_gaw && m_gw) begin
                    if (m_a < NR * 4) begin
                        logic [31:0] mask;
                        mask = 0;
                        for (int b = 0; b < 4; b++)
                            if (m_s[b]) mask = mask | (32'hFF << (8 * b));
                        mregs[m_a / 4] = (mregs[m_a / 4] & ~mask) | (m_d & mask);
                        m_br = 2'b00;
                    end else begin
                        m_br = 2'b10;
                    end
                    m_bv = 1; m_awr = 0; m_wr = 0; m_gaw = 0; m_gw = 0;
                end else begin
                    m_awr = !m_gaw; m_wr = !m_gw;
                end
            end
        end
        #1;
        chk("awready", awready, m_awr);
        chk("wready", wready, m_wr);
        chk("arready", arready, m_arr);
        chk("bvalid", bvalid, m_bv);
        chk("rvalid", rvalid, m_rv);
        if (m_bv || m_rst) chk("bresp", bresp, m_br);
        if (m_rv || m_rst) begin
            chk("rdata", rdata, m_rd);
            chk("rresp", rresp, m_rr);
        end
        for (int k = 0; k < NR; k++)
            chk("regs_out", regs_out[k*DW +: DW], mregs[k]);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; returns on the falling edge after the
    // last requested handshake.
    task automatic xfer(input bit en_aw, input logic [31:0] a,
                        input bit en_w, input logic [31:0] d,
                        input logic [3:0] s,
                        input bit en_ar, input logic [31:0] ra);
        bit h_aw, h_w, h_ar;
        awvalid = en_aw; awaddr = a;
        wvalid = en_w; wdata = d; wstrb = s;
        arvalid = en_ar; araddr = ra;
        for (int k = 0; k < 20 && (awvalid || wvalid || arvalid); k++) begin
            h_aw = awvalid && awready;
            h_w  = wvalid && wready;
            h_ar = arvalid && arready;
            @(negedge clk);
            if (h_aw) awvalid = 0;
            if (h_w) wvalid = 0;
            if (h_ar) arvalid = 0;
        end
        if (awvalid || wvalid || arvalid) begin
            chk("xfer_timeout", {29'd0, awvalid, wvalid, arvalid}, 0);
            awvalid = 0; wvalid = 0; arvalid = 0;
        end
    endtask

    initial begin
        tick(3);
        chk("rst_awready", awready, 0);
        chk("rst_arready", arready, 0);
        chk("rst_bvalid", bvalid, 0);
        rst = 0;
        @(posedge clk); #1;
        chk("post_rst_ready", {awready, wready, arready}, 3'b111);
        @(negedge clk);

        xfer(1, 32'h08, 1, 32'hDEADBEEF, 4'hF, 0, 0);
        chk("w08_bvalid", bvalid, 1);
        chk("w08_bresp", bresp, 2'b00);
        chk("w08_reg2", regs_out[2*DW +: DW], 32'hDEADBEEF);
        xfer(0, 0, 0, 0, 0, 1, 32'h08);
        chk("r08_rdata", rdata, 32'hDEADBEEF);
        chk("r08_rresp", rresp, 2'b00);

        xfer(1, 32'h04, 1, 32'hAABBCCDD, 4'hF, 0, 0);
        xfer(0, 0, 1, 32'h11223344, 4'h5, 0, 0);
        chk("w_first_wready", wready, 0);
        tick(2);
        xfer(1, 32'h04, 0, 0, 0, 0, 0);
        chk("w04_bvalid", bvalid, 1);
        chk("w04_reg1", regs_out[1*DW +: DW], 32'hAA22CC44);

        xfer(1, 32'h40, 1, 32'h12345678, 4'hF, 0, 0);
        chk("w40_bresp", bresp, 2'b10);
        xfer(0, 0, 0, 0, 0, 1, 32'h100);
        chk("r100_rresp", rresp, 2'b10);
        chk("r100_rdata", rdata, 0);

        xfer(1, 32'h0C, 1, 32'h1, 4'hF, 0, 0);
        tick(2);
        xfer(1, 32'h0C, 1, 32'h2, 4'hF, 1, 32'h0C);
        chk("same_cyc_old", rdata, 32'h1);
        tick(1);
        xfer(0, 0, 0, 0, 0, 1, 32'h0C);
        chk("same_cyc_new", rdata, 32'h2);

        for (int i = 0; i < 4; i++)
            xfer(1, 32'h10 + 4 * i, 1, 32'h01020304 * (i + 1), 4'hF >> i, 0, 0);
        for (int i = 0; i < 4; i++)
            xfer(0, 0, 0, 0, 0, 1, 32'h10 + 4 * i);

        tick(2);
        bready = 0; rready = 0;
        xfer(1, 32'h14, 1, 32'hCAFEF00D, 4'hF, 1, 32'h08);
        tick(5);
        chk("hold_bvalid", bvalid, 1);
        chk("hold_rdata", rdata, 32'hDEADBEEF);
        chk("hold_readies", {awready, wready, arready}, 0);
        bready = 1; rready = 1;
        tick(2);
        chk("release_readies", {awready, wready, arready}, 3'b111);

        xfer(1, 32'h10, 0, 0, 0, 0, 0);
        chk("aw_only_wready", wready, 1);
        wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
        rst = 1;
        tick(2);
        rst = 0; wvalid = 0;
        @(posedge clk); #1;
        chk("rst_mid_ready", {awready, wready, arready}, 3'b111);
        chk("rst_mid_reg4", regs_out[4*DW +: DW], 0);
        @(negedge clk);
        tick(3);
        chk("rst_mid_nob", bvalid, 0);

        xfer(1, 32'h3C, 1, 32'hF0F0F0F0, 4'hC, 0, 0);
        chk("w3c_reg15", regs_out[15*DW +: DW], 32'hF0F00000);
        tick(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
